spi_sensor_seq: RTL and testbench
=================================

// Module: spi_sensor_seq
// PURPOSE
//  Parametrised successor to the single-sensor SPI command FSM. Drives the SPI master (data_select/transfer/receive/
//  data_size, handshake on done) for N_CH sensors on separate active-low chip selects: per-channel config write,
//  periodic paced read rounds (CMD+DATA in one CS frame), CS gap timing, and a per-channel soft-reset sequence on power-off.
// PARAMETERS
//  N_CH         2    number of sensors / chip-select lines (>=1)
//  SIZE_W       3    width of data_size; every *_BYTES must be < 2**SIZE_W
//  CFG_BYTES    3    bytes in measurement-mode config write (data_select 2'b01)
//  CMD_BYTES    2    bytes in read command (data_select 2'b10)
//  RD_BYTES     6    bytes clocked in during data read (data_select 2'b00, receive=1)
//  RST_BYTES    3    bytes in soft-reset write (data_select 2'b11)
//  GAP_CYC      4    cycles all cs_n held high between frames (>=1)
//  PERIOD_W     16   width of period input
//  TIMEOUT_CYC  1024 done watchdog limit (only with SPI_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1                 system clock, all logic on posedge
//  rst_n        in   1                 asynchronous active-low reset
//  power        in   1                 1 = run, 0 = shut sensors down
//  done         in   1                 1-cycle pulse from SPI master: current transaction finished
//  period       in   PERIOD_W          clk cycles between read-round starts; sampled at each round start
//  data_select  out  2                 SPI command selector
//  transfer     out  1                 SPI transaction enable
//  receive      out  1                 capture MISO (READ_DATA only)
//  cs_n         out  N_CH              active-low chip selects, at most one bit low
//  data_size    out  SIZE_W            byte count of current transaction
//  ch           out  max(1,$clog2(N_CH)) channel index of current/last transaction
//  sample_valid out  1                 1-cycle pulse: RD_BYTES for channel ch received
//  busy         out  1                 state != IDLE
//  err          out  1                 sticky watchdog error (tied 0 without macro)
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, ch=0, cs_n='1, transfer=receive=sample_valid=busy=err=0, data_select=0,
//   data_size=0, counters 0. Reset mid-transaction aborts at once; cs_n high in the same cycle rst_n falls.
//  States: IDLE, CFG, GAP, WAIT, READ_CMD, READ_DATA, SOFT_RST. Outputs are Moore, cs_n registered.
//  Transaction states (CFG, READ_CMD, READ_DATA, SOFT_RST): transfer=1, cs_n[ch]=0, data_select/data_size per table
//   above; leave only on done. done outside transaction states is ignored.
//  IDLE: power=1 -> CFG ch=0 next cycle (transfer high 1 cycle after power sampled).
//  CFG done -> GAP; after GAP: next ch CFG, or after ch N_CH-1 -> round start.
//  Round start: period counter loaded with period, decrements to 0 (saturating) every cycle; go READ_CMD ch=0.
//  READ_CMD done -> READ_DATA, cs_n[ch] stays low (one frame). READ_DATA done -> sample_valid=1 next cycle, ch held,
//   GAP. After GAP: next ch READ_CMD, else WAIT. WAIT exits to round start when counter==0.
//  Overrun: round longer than period -> next round starts directly after final GAP; period=0 -> back-to-back rounds.
//  power is checked only at frame boundaries (end of GAP, in WAIT, in IDLE); a frame in progress always completes.
//   power=0 at a boundary -> SOFT_RST ch=0, GAP, ..., ch N_CH-1, GAP -> IDLE. power returning during the
//   shutdown sequence is ignored until IDLE; then restarts from CFG.
//  done coincident with power fall: treated as normal completion, shutdown starts at next boundary.
//  GAP counter: loads GAP_CYC-1 on entry, exit when 0; all cs_n high, transfer=0 throughout GAP/WAIT/IDLE.
// CONFIGURATION
//  SPI_SEQ_TIMEOUT_EN defined: per-transaction counter cleared on entry to each transaction state; reaching TIMEOUT_CYC
//   without done -> cs_n='1, err=1 (sticky), enter shutdown sequence at SOFT_RST ch=0; a timeout inside SOFT_RST skips
//   to IDLE. err clears on IDLE->CFG. Not defined: no counter, transaction waits for done indefinitely, err=0.
// TESTING  (N_CH=2, GAP_CYC=4, period=100, done pulsed 10 cycles after transfer rises unless noted)
//  1 Power-up: power=1 -> CFG ch0 sel=01 size=3 cs_n=2'b10; 4 cycles cs_n=2'b11; CFG ch1 cs_n=2'b01; GAP; READ_CMD ch0.
//  2 Read round: READ_CMD sel=10 size=2 then READ_DATA sel=00 receive=1 size=6, cs_n low across both; sample_valid
//    pulses with ch=0 then ch=1; next round READ_CMD exactly 100 cycles after previous round start.
//  3 period=0 and period=5 (overrun) -> rounds separated only by 4-cycle GAP, no WAIT cycles.
//  4 power=0 during READ_CMD ch1 -> frame completes, sample_valid ch=1, then SOFT_RST ch0, ch1 (sel=11 size=3), IDLE, busy=0.
//  5 rst_n low during READ_DATA -> same cycle cs_n=2'b11 transfer=0; after release IDLE until power sampled high.
//  6 SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYC=64, done held low in CFG -> at cycle 64 cs_n=2'b11 err=1, SOFT_RST ch0;
//    without macro the bench sees CFG held for 2000 cycles, err=0.

Source files
------------

// File: rtl/spi_sensor_seq.sv
// spi_sensor_seq: N_CH-channel SPI sensor sequencer (config, paced reads, soft reset).
// Define SPI_SEQ_TIMEOUT_EN to enable the done watchdog and sticky err.
module spi_sensor_seq #(
    parameter int N_CH        = 2,
    parameter int SIZE_W      = 3,
    parameter int CFG_BYTES   = 3,
    parameter int CMD_BYTES   = 2,
    parameter int RD_BYTES    = 6,
    parameter int RST_BYTES   = 3,
    parameter int GAP_CYC     = 4,
    parameter int PERIOD_W    = 16,
    parameter int TIMEOUT_CYC = 1024,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                power,
    input  logic                done,
    input  logic [PERIOD_W-1:0] period,
    output logic [1:0]          data_select,
    output logic                transfer,
    output logic                receive,
    output logic [N_CH-1:0]     cs_n,
    output logic [SIZE_W-1:0]   data_size,
    output logic [CH_W-1:0]     ch,
    output logic                sample_valid,
    output logic                busy,
    output logic                err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CFG       = 3'd1;
    localparam logic [2:0] GAP       = 3'd2;
    localparam logic [2:0] WAIT      = 3'd3;
    localparam logic [2:0] READ_CMD  = 3'd4;
    localparam logic [2:0] READ_DATA = 3'd5;
    localparam logic [2:0] SOFT_RST  = 3'd6;

    localparam logic [1:0] PH_CFG = 2'd0;
    localparam logic [1:0] PH_RD  = 2'd1;
    localparam logic [1:0] PH_SD  = 2'd2;
    localparam logic [1:0] PH_ABT = 2'd3;

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    if (N_CH < 1 || GAP_CYC < 1 || TIMEOUT_CYC < 1 ||
        CFG_BYTES >= (1 << SIZE_W) || CMD_BYTES >= (1 << SIZE_W) ||
        RD_BYTES >= (1 << SIZE_W) || RST_BYTES >= (1 << SIZE_W)) begin : g_param_check
        $error("spi_sensor_seq: invalid parameter set");
    end

    logic [2:0]          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [1:0]          phase_q, phase_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] per_load;
    logic [CH_W-1:0]     ch_inc;
    logic                last_ch;
    logic                round_go;
    logic                shut_go;
    logic                to_hit;

    logic                xfer_d;
    logic                recv_d;
    logic [1:0]          sel_d;
    logic [SIZE_W-1:0]   size_d;
    logic                sv_d;

    assign ch_inc  = ch_q + CH_W'(1);
    assign last_ch = (ch_q == CH_W'(N_CH - 1));
    assign ch      = ch_q;

    // Counter holds the cycles left after the round-start cycle itself.
    assign per_load = (period != '0) ? period - PERIOD_W'(1) : '0;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        phase_d  = phase_q;
        gap_d    = gap_q;
        per_d    = (per_q != '0) ? per_q - PERIOD_W'(1) : '0;
        round_go = 1'b0;
        shut_go  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (power) begin
                    state_d = CFG;
                    ch_d    = '0;
                    phase_d = PH_CFG;
                end
            end
            CFG, READ_DATA, SOFT_RST: begin
                if (done) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            READ_CMD: begin
                if (done) state_d = READ_DATA;
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (phase_q == PH_SD) begin
                    if (last_ch) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SOFT_RST;
                        ch_d    = ch_inc;
                    end
                end else if (phase_q == PH_ABT || !power) begin
                    shut_go = 1'b1;
                end else if (!last_ch) begin
                    state_d = (phase_q == PH_CFG) ? CFG : READ_CMD;
                    ch_d    = ch_inc;
                end else if (phase_q == PH_CFG || per_q == '0) begin
                    round_go = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!power) shut_go = 1'b1;
                else if (per_q == '0) round_go = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (round_go) begin
            state_d = READ_CMD;
            ch_d    = '0;
            phase_d = PH_RD;
            per_d   = per_load;
        end
        if (shut_go) begin
            state_d = SOFT_RST;
            ch_d    = '0;
            phase_d = PH_SD;
        end
        // Abort: drop cs_n, then shut down (or just stop if already resetting).
        if (to_hit) begin
            state_d = (state_q == SOFT_RST) ? IDLE : GAP;
            phase_d = PH_ABT;
            gap_d   = GAP_LOAD;
        end
    end

    always_comb begin
        xfer_d = 1'b0;
        recv_d = 1'b0;
        sel_d  = 2'b00;
        size_d = '0;
        case (state_d)
            CFG: begin
                xfer_d = 1'b1;
                sel_d  = 2'b01;
                size_d = SIZE_W'(CFG_BYTES);
            end
            READ_CMD: begin
                xfer_d = 1'b1;
                sel_d  = 2'b10;
                size_d = SIZE_W'(CMD_BYTES);
            end
            READ_DATA: begin
                xfer_d = 1'b1;
                recv_d = 1'b1;
                size_d = SIZE_W'(RD_BYTES);
            end
            SOFT_RST: begin
                xfer_d = 1'b1;
                sel_d  = 2'b11;
                size_d = SIZE_W'(RST_BYTES);
            end
            default: ;
        endcase
    end

    assign sv_d = (state_q == READ_DATA) && done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            phase_q      <= PH_CFG;
            gap_q        <= '0;
            per_q        <= '0;
            cs_n         <= '1;
            transfer     <= 1'b0;
            receive      <= 1'b0;
            data_select  <= 2'b00;
            data_size    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            phase_q      <= phase_d;
            gap_q        <= gap_d;
            per_q        <= per_d;
            cs_n         <= ~(N_CH'(xfer_d) << ch_d);
            transfer     <= xfer_d;
            receive      <= recv_d;
            data_select  <= sel_d;
            data_size    <= size_d;
            sample_valid <= sv_d;
            busy         <= (state_d != IDLE);
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_q;
    logic            in_xfer;
    logic            err_q;

    assign in_xfer = (state_q == CFG) || (state_q == READ_CMD) ||
                     (state_q == READ_DATA) || (state_q == SOFT_RST);
    assign to_hit  = in_xfer && !done &&
                     (to_q == TO_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q) to_q <= '0;
            else if (in_xfer) to_q <= to_q + TO_W'(1);
            if (state_q == IDLE && power) err_q <= 1'b0;
            else if (to_hit) err_q <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sensor_seq.sv
// tb_spi_sensor_seq: directed bench for spi_sensor_seq (N_CH=2, GAP_CYC=4).
// Table of expected transactions plus hand sequences for reset/shutdown/hold.
module tb_spi_sensor_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power;
    logic        done;
    logic [15:0] period;
    logic [1:0]  data_select;
    logic        transfer;
    logic        receive;
    logic [1:0]  cs_n;
    logic [2:0]  data_size;
    logic        ch;
    logic        sample_valid;
    logic        busy;
    logic        err;

    spi_sensor_seq #(
        .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .power(power),
        .done(done),
        .period(period),
        .data_select(data_select),
        .transfer(transfer),
        .receive(receive),
        .cs_n(cs_n),
        .data_size(data_size),
        .ch(ch),
        .sample_valid(sample_valid),
        .busy(busy),
        .err(err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic [2:0] size;
        logic [1:0] cs;
        logic       rv;
        logic       ch;
    } txn_t;

    typedef struct {
        int   cyc;
        logic ch;
    } sv_t;

    typedef struct {
        int         per;
        int         off;
        logic [1:0] sel;
        logic [2:0] size;
        logic [1:0] cs;
        logic       rv;
        logic       pwr;
    } vec_t;

    txn_t txq[$];
    sv_t  svq[$];
    vec_t tbl[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    int age = 0;
    logic rsp_en = 1'b1;
    logic prev_tr = 1'b0;
    logic [1:0] prev_sel = 2'b00;

    int roff[5] = '{28, 128, 176, 224, 324};
    int rper[5] = '{100, 0, 5, 100, 100};

    // Monitor + SPI master model: done 10 cycles after each transaction starts.
    initial begin
        done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (transfer && (!prev_tr || data_select != prev_sel)) begin
                txq.push_back('{cyc, data_select, data_size, cs_n, receive, ch});
                age = 1;
            end else if (transfer) begin
                age++;
            end else begin
                age = 0;
            end
            done = rsp_en && transfer && (age == 10);
            if (sample_valid) svq.push_back('{cyc, ch});
            if ((!transfer && cs_n != 2'b11) ||
                (transfer && cs_n != 2'b10 && cs_n != 2'b01)) viol++;
            prev_tr  = transfer;
            prev_sel = data_select;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic wait_txn(input int n, output bit ok);
        int k;
        k = 0;
        while (txq.size() <= n && k < 600) begin
            tick();
            k++;
        end
        ok = (txq.size() > n);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL txn_wait: got %0d transactions, required %0d",
                     txq.size(), n + 1);
        end
    endtask

    initial begin
        txn_t t;
        bit   ok;
        int   p0;
        int   k;
        int   n;
        int   c;

        rst_n  = 1'b0;
        power  = 1'b0;
        period = 16'd100;

        tbl.push_back('{100, 0, 2'b01, 3'd3, 2'b10, 1'b0, 1'b1});
        tbl.push_back('{100, 14, 2'b01, 3'd3, 2'b01, 1'b0, 1'b1});
        for (int r = 0; r < 5; r++) begin
            tbl.push_back('{rper[r], roff[r], 2'b10, 3'd2, 2'b10, 1'b0, 1'b1});
            tbl.push_back('{rper[r], roff[r] + 10, 2'b00, 3'd6, 2'b10, 1'b1, 1'b1});
            tbl.push_back('{rper[r], roff[r] + 24, 2'b10, 3'd2, 2'b01, 1'b0, r != 4});
            tbl.push_back('{rper[r], roff[r] + 34, 2'b00, 3'd6, 2'b01, 1'b1, r != 4});
        end
        tbl.push_back('{100, 372, 2'b11, 3'd3, 2'b10, 1'b0, 1'b0});
        tbl.push_back('{100, 386, 2'b11, 3'd3, 2'b01, 1'b0, 1'b0});

        tick();
        tick();
        tick();
        chk("reset_outputs",
            {cs_n, transfer, receive, sample_valid, busy, err,
             data_select, data_size, ch} == 13'h1800,
            $sformatf("got cs_n=%b tr=%b rx=%b sv=%b busy=%b err=%b sel=%b size=%0d ch=%0d, required cs_n=11 rest 0",
                      cs_n, transfer, receive, sample_valid, busy, err,
                      data_select, data_size, ch));
        rst_n = 1'b1;
        tick();
        tick();
        power = 1'b1;
        p0 = cyc + 1;

        for (int i = 0; i < tbl.size(); i++) begin
            period = 16'(tbl[i].per);
            wait_txn(i, ok);
            if (!ok) break;
            t = txq[i];
            chk($sformatf("txn%0d", i),
                (t.cyc - p0 == tbl[i].off) && t.sel == tbl[i].sel &&
                t.size == tbl[i].size && t.cs == tbl[i].cs && t.rv == tbl[i].rv,
                $sformatf("got off=%0d sel=%b size=%0d cs_n=%b rx=%b, required off=%0d sel=%b size=%0d cs_n=%b rx=%b",
                          t.cyc - p0, t.sel, t.size, t.cs, t.rv, tbl[i].off,
                          tbl[i].sel, tbl[i].size, tbl[i].cs, tbl[i].rv));
            power = tbl[i].pwr;
        end

        k = 0;
        while (cyc < p0 + 399 && k < 1000) begin
            tick();
            k++;
        end
        chk("busy_last_gap", busy == 1'b1,
            $sformatf("got busy=%b at off=%0d, required 1 at off=399", busy, cyc - p0));
        tick();
        chk("idle_after_shutdown",
            busy == 1'b0 && transfer == 1'b0 && cs_n == 2'b11,
            $sformatf("got busy=%b tr=%b cs_n=%b at off=%0d, required 0 0 11 at off=400",
                      busy, transfer, cs_n, cyc - p0));

        chk("sv_count", svq.size() == 10,
            $sformatf("got %0d sample_valid pulses, required 10", svq.size()));
        for (int i = 0; i < 10 && i < svq.size(); i++) begin
            chk($sformatf("sv%0d", i),
                svq[i].cyc - p0 == roff[i / 2] + ((i % 2 == 0) ? 20 : 44) &&
                svq[i].ch == 1'(i % 2),
                $sformatf("got off=%0d ch=%0d, required off=%0d ch=%0d",
                          svq[i].cyc - p0, svq[i].ch,
                          roff[i / 2] + ((i % 2 == 0) ? 20 : 44), i % 2));
        end

        chk("cs_n_legal", viol == 0,
            $sformatf("got %0d illegal cs_n/transfer cycles, required 0", viol));

        n = txq.size();
        c = cyc;
        power = 1'b1;
        wait_txn(n, ok);
        if (ok) begin
            t = txq[n];
            chk("restart_cfg",
                t.cyc == c + 1 && t.sel == 2'b01 && t.cs == 2'b10 && t.ch == 1'b0,
                $sformatf("got delay=%0d sel=%b cs_n=%b ch=%0d, required delay=1 sel=01 cs_n=10 ch=0",
                          t.cyc - c, t.sel, t.cs, t.ch));
        end

        k = 0;
        while (!receive && k < 200) begin
            tick();
            k++;
        end
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        power = 1'b0;
        #1;
        chk("async_reset_abort",
            cs_n == 2'b11 && transfer == 1'b0 && receive == 1'b0 && busy == 1'b0,
            $sformatf("got cs_n=%b tr=%b rx=%b busy=%b, required 11 0 0 0",
                      cs_n, transfer, receive, busy));
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_after_reset",
            busy == 1'b0 && transfer == 1'b0 && cs_n == 2'b11 && ch == 1'b0,
            $sformatf("got busy=%b tr=%b cs_n=%b ch=%0d, required 0 0 11 0",
                      busy, transfer, cs_n, ch));
        power = 1'b1;
        tick();
        rsp_en = 1'b0;
        chk("cfg_after_reset",
            transfer == 1'b1 && data_select == 2'b01 && cs_n == 2'b10 && data_size == 3'd3,
            $sformatf("got tr=%b sel=%b cs_n=%b size=%0d, required 1 01 10 3",
                      transfer, data_select, cs_n, data_size));

        n = txq.size();
`ifdef SPI_SEQ_TIMEOUT_EN
        k = 0;
        while (cs_n != 2'b11 && k < 200) begin
            tick();
            k++;
        end
        chk("timeout_abort", k == 64 && err == 1'b1 && transfer == 1'b0,
            $sformatf("got cycles=%0d err=%b tr=%b, required 64 1 0", k, err, transfer));
        rsp_en = 1'b1;
        wait_txn(n, ok);
        if (ok) begin
            t = txq[n];
            chk("timeout_soft_rst", t.sel == 2'b11 && t.ch == 1'b0 && t.cs == 2'b10,
                $sformatf("got sel=%b ch=%0d cs_n=%b, required 11 0 10", t.sel, t.ch, t.cs));
        end
`else
        repeat (2000) tick();
        chk("cfg_hold_no_timeout",
            transfer == 1'b1 && data_select == 2'b01 && cs_n == 2'b10 &&
            err == 1'b0 && busy == 1'b1 && txq.size() == n,
            $sformatf("got tr=%b sel=%b cs_n=%b err=%b busy=%b new_txn=%0d, required 1 01 10 0 1 0",
                      transfer, data_select, cs_n, err, busy, txq.size() - n));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
